// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Renderer-side raster bus. The timing generator drives it;
//               sprite renderers and game logic listen on it.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        line_start;
    logic        frame_start;
    logic        vblank_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs,
        output line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs,
        input line_start, frame_start, vblank_start, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 raster timing. Free-running pixel/line counters
//               exposed as DrawX/DrawY, sync and blank delayed to line up
//               with the renderers' pixel pipeline, plus line/frame strobes
//               and a frame counter for game logic.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_DELAY  = 2,
    parameter int BLANK_DELAY = 1
) (
    input  wire logic          vga_clk,
    input  wire logic          reset,
    vga_timing_gen_if.master   vga
);

    localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic [15:0] r_frame_count;

    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_blank_raw;
    logic        w_line_start;

    // Pixel/line counters with frame counter bumped on the final pixel of the frame
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_count <= '0;
        end else if (r_hc == c_h_last) begin
            r_hc <= '0;
            if (r_vc == c_v_last) begin
                r_vc          <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_vc <= r_vc + 10'd1;
            end
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    assign w_hs_raw    = !((r_hc >= c_hs_start) && (r_hc < c_hs_end));
    assign w_vs_raw    = !((r_vc >= c_vs_start) && (r_vc < c_vs_end));
    assign w_blank_raw = (r_hc < c_h_active) && (r_vc < c_v_active);

    // Strobes come straight off the counters so game logic sees them in the
    // same cycle as the matching DrawX/DrawY.
    assign w_line_start     = (r_hc == 10'd0);
    assign vga.line_start   = w_line_start;
    assign vga.frame_start  = w_line_start && (r_vc == 10'd0);
    assign vga.vblank_start = w_line_start && (r_vc == c_v_active);

    assign vga.DrawX       = r_hc;
    assign vga.DrawY       = r_vc;
    assign vga.frame_count = r_frame_count;

    generate
        if (SYNC_DELAY == 0) begin : g_sync_direct
            assign vga.hs = w_hs_raw;
            assign vga.vs = w_vs_raw;
        end else begin : g_sync_pipe
            logic [SYNC_DELAY-1:0] r_hs_pipe;
            logic [SYNC_DELAY-1:0] r_vs_pipe;

            // Sync shift chain; stages reset to the inactive (high) level
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    r_hs_pipe <= '1;
                    r_vs_pipe <= '1;
                end else begin
                    r_hs_pipe[0] <= w_hs_raw;
                    r_vs_pipe[0] <= w_vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign vga.hs = r_hs_pipe[SYNC_DELAY-1];
            assign vga.vs = r_vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

    generate
        if (BLANK_DELAY == 0) begin : g_blank_direct
            assign vga.blank = w_blank_raw;
        end else begin : g_blank_pipe
            logic [BLANK_DELAY-1:0] r_blank_pipe;

            // Blank shift chain; stages reset to "not visible"
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    r_blank_pipe <= '0;
                end else begin
                    r_blank_pipe[0] <= w_blank_raw;
                    for (int i = 1; i < BLANK_DELAY; i++) begin
                        r_blank_pipe[i] <= r_blank_pipe[i-1];
                    end
                end
            end

            assign vga.blank = r_blank_pipe[BLANK_DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Bench for vga_timing_gen. Three builds: full 640x480 timing,
//               a shrunken raster for whole-frame behaviour, and a
//               zero-delay sync/blank build. Expected outputs come from a
//               cycle-number model of the raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen u_a (.vga_clk(vga_clk), .reset(rst_a), .vga(if_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_DELAY(2), .BLANK_DELAY(1)
    ) u_b (.vga_clk(vga_clk), .reset(rst_b), .vga(if_b));

    vga_timing_gen #(
        .SYNC_DELAY(0), .BLANK_DELAY(0)
    ) u_c (.vga_clk(vga_clk), .reset(rst_c), .vga(if_c));

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        vbs;
        logic [15:0] fc;
    } vga_t;

    vga_t obs_a, obs_b, obs_c;
    always_comb obs_a = {if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hs, if_a.vs,
                         if_a.line_start, if_a.frame_start, if_a.vblank_start, if_a.frame_count};
    always_comb obs_b = {if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hs, if_b.vs,
                         if_b.line_start, if_b.frame_start, if_b.vblank_start, if_b.frame_count};
    always_comb obs_c = {if_c.DrawX, if_c.DrawY, if_c.blank, if_c.hs, if_c.vs,
                         if_c.line_start, if_c.frame_start, if_c.vblank_start, if_c.frame_count};

    // Cycles elapsed since each build last left reset (cycle 0 = first cycle out of reset)
    longint t_a = 0, t_b = 0, t_c = 0;
    always @(posedge vga_clk) t_a <= rst_a ? 64'd0 : t_a + 1;
    always @(posedge vga_clk) t_b <= rst_b ? 64'd0 : t_b + 1;
    always @(posedge vga_clk) t_c <= rst_c ? 64'd0 : t_c + 1;

    int passed = 0;
    int total  = 0;

    // Raster as a function of elapsed cycles: position is t mod the line and
    // frame lengths; delayed outputs look at position t-delay, or the idle
    // level when that lies before reset.
    function automatic vga_t model(input longint t, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input int sd, input int bd);
        vga_t   m;
        longint ht, vt, d, px, py;
        ht   = longint'(ha + hf + hsw + hb);
        vt   = longint'(va + vf + vsw + vb);
        m.x  = 10'(t % ht);
        m.y  = 10'((t / ht) % vt);
        m.fc = 16'((t / (ht * vt)) % 65536);
        m.ls  = (t % ht) == 0;
        m.fs  = m.ls && ((t / ht) % vt) == 0;
        m.vbs = m.ls && ((t / ht) % vt) == longint'(va);
        if (t < longint'(sd)) begin
            m.hs = 1'b1;
            m.vs = 1'b1;
        end else begin
            d  = t - longint'(sd);
            px = d % ht;
            py = (d / ht) % vt;
            m.hs = !(px >= ha + hf && px < ha + hf + hsw);
            m.vs = !(py >= va + vf && py < va + vf + vsw);
        end
        if (t < longint'(bd)) begin
            m.blank = 1'b0;
        end else begin
            d  = t - longint'(bd);
            px = d % ht;
            py = (d / ht) % vt;
            m.blank = (px < ha) && (py < va);
        end
        return m;
    endfunction

    function automatic vga_t model_a(input longint t);
        return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1);
    endfunction
    function automatic vga_t model_b(input longint t);
        return model(t, 8, 2, 3, 3, 6, 1, 2, 1, 2, 1);
    endfunction
    function automatic vga_t model_c(input longint t);
        return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
    endfunction

    // Reset value seen in the first cycle after any reset
    localparam vga_t c_reset_view = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};

    task automatic test_reset();
        vga_t e;
        @(negedge vga_clk); rst_a = 1'b1;
        @(negedge vga_clk); rst_a = 1'b0;
        e = model_a(t_a);
        total++;
        if (obs_a !== e) $display("FAIL reset_model got=%h exp=%h", obs_a, e);
        else passed++;
        total++;
        if (obs_a !== c_reset_view) $display("FAIL reset_state got=%h exp=%h", obs_a, c_reset_view);
        else passed++;
    endtask

    // First line plus the wrap into line 1, including hs/blank edges
    task automatic test_line();
        vga_t e;
        logic exp_bit;
        for (int k = 0; k <= 800; k++) begin
            e = model_a(t_a);
            total++;
            if (obs_a !== e) $display("FAIL line t=%0d got=%h exp=%h", t_a, obs_a, e);
            else passed++;
            if (k == 657 || k == 658 || k == 753 || k == 754) begin
                exp_bit = (k == 658 || k == 753) ? 1'b0 : 1'b1;
                total++;
                if (if_a.hs !== exp_bit) $display("FAIL hs_edge t=%0d got=%b exp=%b", k, if_a.hs, exp_bit);
                else passed++;
            end
            if (k == 0 || k == 1 || k == 640 || k == 641) begin
                exp_bit = (k == 1 || k == 640) ? 1'b1 : 1'b0;
                total++;
                if (if_a.blank !== exp_bit) $display("FAIL blank_edge t=%0d got=%b exp=%b", k, if_a.blank, exp_bit);
                else passed++;
            end
            if (k == 800) begin
                total++;
                if (if_a.DrawX !== 10'd0 || if_a.DrawY !== 10'd1 || if_a.line_start !== 1'b1)
                    $display("FAIL line_wrap x=%0d y=%0d ls=%b exp x=0 y=1 ls=1",
                             if_a.DrawX, if_a.DrawY, if_a.line_start);
                else passed++;
            end
            @(negedge vga_clk);
        end
    endtask

    // Random run lengths, then a one-cycle reset somewhere mid-frame
    task automatic test_mid_reset();
        vga_t e;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(300, 3000);
            for (int k = 0; k < n; k++) begin
                e = model_a(t_a);
                total++;
                if (obs_a !== e) $display("FAIL mid_run t=%0d got=%h exp=%h", t_a, obs_a, e);
                else passed++;
                @(negedge vga_clk);
            end
            rst_a = 1'b1;
            @(negedge vga_clk); rst_a = 1'b0;
            total++;
            if (obs_a !== c_reset_view) $display("FAIL mid_reset got=%h exp=%h", obs_a, c_reset_view);
            else passed++;
        end
    endtask

    // Vertical sync and vblank strobe on the small raster (16 x 10)
    task automatic test_vsync();
        vga_t   e;
        longint fall = -1, rise = -1, vb_at = -1;
        int     vb_cnt = 0;
        logic   prev_vs = 1'b1;
        @(negedge vga_clk); rst_b = 1'b1;
        @(negedge vga_clk); rst_b = 1'b0;
        for (int k = 0; k < 320; k++) begin
            e = model_b(t_b);
            total++;
            if (obs_b !== e) $display("FAIL vsync_run t=%0d got=%h exp=%h", t_b, obs_b, e);
            else passed++;
            if (prev_vs && !if_b.vs && fall < 0) fall = t_b;
            if (!prev_vs && if_b.vs && rise < 0) rise = t_b;
            if (k < 160 && if_b.vblank_start) begin vb_cnt++; vb_at = t_b; end
            prev_vs = if_b.vs;
            @(negedge vga_clk);
        end
        // vs falls 2 cycles after (0,7), rises 2 cycles after (0,9)
        total++;
        if (fall != 114 || rise != 146) $display("FAIL vs_edges fall=%0d rise=%0d exp 114 146", fall, rise);
        else passed++;
        total++;
        if (vb_cnt != 1 || vb_at != 96) $display("FAIL vblank_pulse cnt=%0d at=%0d exp 1 at 96", vb_cnt, vb_at);
        else passed++;
    endtask

    // Three frames: frame_start spacing and frame_count after each wrap
    task automatic test_frames();
        vga_t   e;
        longint fs_t[$];
        @(negedge vga_clk); rst_b = 1'b1;
        @(negedge vga_clk); rst_b = 1'b0;
        for (int k = 0; k <= 482; k++) begin
            e = model_b(t_b);
            total++;
            if (obs_b !== e) $display("FAIL frames_run t=%0d got=%h exp=%h", t_b, obs_b, e);
            else passed++;
            if (if_b.frame_start) fs_t.push_back(t_b);
            if (t_b == 160 || t_b == 320 || t_b == 480) begin
                total++;
                if (if_b.frame_count !== 16'(t_b / 160))
                    $display("FAIL frame_count t=%0d got=%0d exp=%0d", t_b, if_b.frame_count, t_b / 160);
                else passed++;
            end
            @(negedge vga_clk);
        end
        total++;
        if (fs_t.size() != 4) $display("FAIL frame_pulses got=%0d exp=4", fs_t.size());
        else passed++;
        for (int i = 1; i < fs_t.size(); i++) begin
            total++;
            if (fs_t[i] - fs_t[i-1] != 160)
                $display("FAIL frame_period got=%0d exp=160", fs_t[i] - fs_t[i-1]);
            else passed++;
        end
    endtask

    // frame_count preset to 65535 must roll to 0 at the next frame wrap
    task automatic test_fc_wrap();
        @(negedge vga_clk); rst_b = 1'b1;
        @(negedge vga_clk); rst_b = 1'b0;
        repeat (5) @(negedge vga_clk);
        force u_b.r_frame_count = 16'hFFFF;
        @(negedge vga_clk);
        release u_b.r_frame_count;
        for (int k = 0; k < 400 && t_b < 159; k++) @(negedge vga_clk);
        total++;
        if (if_b.frame_count !== 16'hFFFF || t_b != 159)
            $display("FAIL fc_preset got=%0d t=%0d exp 65535 at 159", if_b.frame_count, t_b);
        else passed++;
        @(negedge vga_clk);
        total++;
        if (if_b.frame_count !== 16'd0 || if_b.frame_start !== 1'b1)
            $display("FAIL fc_wrap got=%0d fs=%b exp 0 fs=1", if_b.frame_count, if_b.frame_start);
        else passed++;
    endtask

    // Zero-delay build: hs falls exactly at hc=656, blank visible at cycle 0
    task automatic test_sync0();
        vga_t   e;
        longint fall = -1;
        @(negedge vga_clk); rst_c = 1'b1;
        @(negedge vga_clk); rst_c = 1'b0;
        for (int k = 0; k <= 800; k++) begin
            e = model_c(t_c);
            total++;
            if (obs_c !== e) $display("FAIL sync0_run t=%0d got=%h exp=%h", t_c, obs_c, e);
            else passed++;
            if (k == 0) begin
                total++;
                if (if_c.blank !== 1'b1) $display("FAIL sync0_blank got=%b exp=1", if_c.blank);
                else passed++;
            end
            if (!if_c.hs && fall < 0) fall = t_c;
            @(negedge vga_clk);
        end
        total++;
        if (fall != 656) $display("FAIL sync0_hs_fall got=%0d exp=656", fall);
        else passed++;
    endtask

    // Random resets and run lengths on the small and zero-delay builds
    task automatic test_random();
        vga_t e;
        int   n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(50, 700);
            @(negedge vga_clk); rst_b = 1'b1; rst_c = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge vga_clk);
            rst_b = 1'b0; rst_c = 1'b0;
            for (int k = 0; k < n; k++) begin
                e = model_b(t_b);
                total++;
                if (obs_b !== e) $display("FAIL rand_b t=%0d got=%h exp=%h", t_b, obs_b, e);
                else passed++;
                e = model_c(t_c);
                total++;
                if (obs_c !== e) $display("FAIL rand_c t=%0d got=%h exp=%h", t_c, obs_c, e);
                else passed++;
                @(negedge vga_clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_vsync();
        test_frames();
        test_fc_wrap();
        test_sync0();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
